// File: rtl/cavlc_mb_scheduler.sv
// cavlc_mb_scheduler
//   Walks the 16 luma 4x4 blocks of one macroblock through the block control
//   FSM in H.264 block-scan order.  For every block it forms the coeff_token
//   context nC from the left/top neighbour TotalCoeff values.  It also records
//   each block's TotalCoeff so that neighbours inside the macroblock can use it.
//
// Ports
//   Clk, nReset             clock, asynchronous active-low reset
//   MbStart                 start a macroblock (accepted in IDLE only)
//   LeftMbAvail/TopMbAvail  neighbour macroblock availability (latched on MbStart)
//   LeftMbTotalCoeff        right column of left MB, row y at [5y+4:5y]
//   TopMbTotalCoeff         bottom row of top MB, column x at [5x+4:5x]
//   BarrelShifterReady      bitstream shifter has valid bits
//   BlockDone, TotalCoeff   block FSM completion pulse and that block's TotalCoeff
//   Enable                  launch request to the block FSM
//   nC, BlkIdx              registered context and index of the current block
//   MbBusy, MbDone          macroblock in progress / completion pulse
//   BotRowTotalCoeff        TotalCoeff of the y=3 blocks, indexed by x
//   RightColTotalCoeff      TotalCoeff of the x=3 blocks, indexed by y
module cavlc_mb_scheduler #(
  parameter int unsigned NUM_BLK = 16,
  parameter int unsigned TC_W    = 5
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                MbStart,
  input  logic                LeftMbAvail,
  input  logic                TopMbAvail,
  input  logic [4*TC_W-1:0]   LeftMbTotalCoeff,
  input  logic [4*TC_W-1:0]   TopMbTotalCoeff,
  input  logic                BarrelShifterReady,
  input  logic                BlockDone,
  input  logic [TC_W-1:0]     TotalCoeff,
  output logic                Enable,
  output logic [TC_W-1:0]     nC,
  output logic [3:0]          BlkIdx,
  output logic                MbBusy,
  output logic                MbDone,
  output logic [4*TC_W-1:0]   BotRowTotalCoeff,
  output logic [4*TC_W-1:0]   RightColTotalCoeff
);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_DONE, FINISH} state_t;

  localparam logic [3:0] LAST_BLK = 4'(NUM_BLK - 1);

  state_t state, nextState;

  logic                leftAvail, topAvail;
  logic [4*TC_W-1:0]   leftTc, topTc;
  logic [TC_W-1:0]     tcTab [NUM_BLK];

  logic [1:0]          blkX, blkY;
  logic [TC_W-1:0]     nA, nB, nCNext;
  logic                availA, availB;
  logic [TC_W:0]       sumAB;
  logic [4*TC_W-1:0]   botNext, rightNext;

  // Scan index from block coordinates: {y1, x1, y0, x0}.
  function automatic logic [3:0] blkOf(input logic [1:0] bx, input logic [1:0] by);
    return {by[1], bx[1], by[0], bx[0]};
  endfunction

  assign blkX = {BlkIdx[2], BlkIdx[0]};
  assign blkY = {BlkIdx[3], BlkIdx[1]};

  // Neighbour selection and nC.
  always_comb begin
    nA     = '0;
    nB     = '0;
    availA = 1'b0;
    availB = 1'b0;
    if (blkX != 2'd0) begin
      nA     = tcTab[blkOf(blkX - 2'd1, blkY)];
      availA = 1'b1;
    end else begin
      nA     = leftTc[blkY*TC_W +: TC_W];
      availA = leftAvail;
    end
    if (blkY != 2'd0) begin
      nB     = tcTab[blkOf(blkX, blkY - 2'd1)];
      availB = 1'b1;
    end else begin
      nB     = topTc[blkX*TC_W +: TC_W];
      availB = topAvail;
    end
    sumAB = {1'b0, nA} + {1'b0, nB} + {{TC_W{1'b0}}, 1'b1};
    case ({availA, availB})
      2'b11:   nCNext = sumAB[TC_W:1];
      2'b10:   nCNext = nA;
      2'b01:   nCNext = nB;
      default: nCNext = '0;
    endcase
  end

  // Edge vectors are captured on the last BlockDone rather than in FINISH, so
  // they are already valid while MbDone is high; block 15 is taken straight
  // from TotalCoeff because its table entry is written on that same edge.
  always_comb begin
    botNext   = '0;
    rightNext = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      botNext[i*TC_W +: TC_W]   = (blkOf(2'(i), 2'd3) == LAST_BLK) ? TotalCoeff
                                                                  : tcTab[blkOf(2'(i), 2'd3)];
      rightNext[i*TC_W +: TC_W] = (blkOf(2'd3, 2'(i)) == LAST_BLK) ? TotalCoeff
                                                                  : tcTab[blkOf(2'd3, 2'(i))];
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (MbStart) nextState = CALC;
      CALC:      nextState = ISSUE;
      ISSUE:     if (BarrelShifterReady) nextState = WAIT_DONE;
      WAIT_DONE: if (BlockDone) nextState = (BlkIdx == LAST_BLK) ? FINISH : CALC;
      FINISH:    nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    Enable = 1'b0;
    MbDone = 1'b0;
    case (state)
      ISSUE:   Enable = 1'b1;
      FINISH:  MbDone = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      leftAvail          <= 1'b0;
      topAvail           <= 1'b0;
      leftTc             <= '0;
      topTc              <= '0;
      nC                 <= '0;
      BlkIdx             <= '0;
      MbBusy             <= 1'b0;
      BotRowTotalCoeff   <= '0;
      RightColTotalCoeff <= '0;
      for (int unsigned i = 0; i < NUM_BLK; i++) tcTab[i] <= '0;
    end else begin
      case (state)
        IDLE: if (MbStart) begin
          leftAvail <= LeftMbAvail;
          topAvail  <= TopMbAvail;
          leftTc    <= LeftMbTotalCoeff;
          topTc     <= TopMbTotalCoeff;
          BlkIdx    <= '0;
          MbBusy    <= 1'b1;
        end
        CALC: nC <= nCNext;
        WAIT_DONE: if (BlockDone) begin
          tcTab[BlkIdx] <= TotalCoeff;
          if (BlkIdx == LAST_BLK) begin
            BotRowTotalCoeff   <= botNext;
            RightColTotalCoeff <= rightNext;
          end else begin
            BlkIdx <= BlkIdx + 4'd1;
          end
        end
        FINISH: MbBusy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_mb_scheduler.sv
// Directed bench for cavlc_mb_scheduler: acts as slice parser and block FSM,
// with hand-computed nC and edge-vector expectations per macroblock.
module tb_cavlc_mb_scheduler;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        MbStart;
  logic        LeftMbAvail, TopMbAvail;
  logic [19:0] LeftMbTotalCoeff, TopMbTotalCoeff;
  logic        BarrelShifterReady;
  logic        BlockDone;
  logic [4:0]  TotalCoeff;
  logic        Enable;
  logic [4:0]  nC;
  logic [3:0]  BlkIdx;
  logic        MbBusy, MbDone;
  logic [19:0] BotRowTotalCoeff, RightColTotalCoeff;

  int tests = 0;
  int fails = 0;

  logic [4:0] tcA [16];
  logic [4:0] ncA [16];

  always #5 Clk = ~Clk;

  cavlc_mb_scheduler #(.NUM_BLK(16), .TC_W(5)) dut (
    .Clk(Clk), .nReset(nReset), .MbStart(MbStart),
    .LeftMbAvail(LeftMbAvail), .TopMbAvail(TopMbAvail),
    .LeftMbTotalCoeff(LeftMbTotalCoeff), .TopMbTotalCoeff(TopMbTotalCoeff),
    .BarrelShifterReady(BarrelShifterReady), .BlockDone(BlockDone),
    .TotalCoeff(TotalCoeff), .Enable(Enable), .nC(nC), .BlkIdx(BlkIdx),
    .MbBusy(MbBusy), .MbDone(MbDone),
    .BotRowTotalCoeff(BotRowTotalCoeff), .RightColTotalCoeff(RightColTotalCoeff)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic startMb(input logic lAv, input logic tAv, input logic [19:0] lTc,
                         input logic [19:0] tTc);
    LeftMbAvail = lAv; TopMbAvail = tAv;
    LeftMbTotalCoeff = lTc; TopMbTotalCoeff = tTc;
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    // Only the latched copies may be used from here on.
    LeftMbAvail = ~lAv; TopMbAvail = ~tAv;
    LeftMbTotalCoeff = ~lTc; TopMbTotalCoeff = ~tTc;
  endtask

  // Block FSM model: wait for Enable, check context, finish the block.
  task automatic doBlock(input logic [4:0] tc, input logic [4:0] expNc, input logic [3:0] expIdx,
                         input int expWait, input int hold, input bit spur);
    int cnt = 0;
    while (Enable !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("enable_latency", cnt, expWait);
    chk("nC", nC, expNc);
    chk("BlkIdx", BlkIdx, expIdx);
    chk("MbBusy", MbBusy, 1);
    if (hold > 0) begin
      BarrelShifterReady = 1'b0;
      for (int k = 0; k < hold; k++) begin
        tick();
        chk("hold_enable", Enable, 1);
        chk("hold_idx", BlkIdx, expIdx);
      end
      BarrelShifterReady = 1'b1;
    end
    tick();
    chk("enable_drop", Enable, 0);
    BlockDone = 1'b1; TotalCoeff = tc;
    tick();
    BlockDone = 1'b0; TotalCoeff = 5'd27;
    if (spur) begin
      BlockDone = 1'b1; TotalCoeff = 5'd31; MbStart = 1'b1;
      tick();
      BlockDone = 1'b0; MbStart = 1'b0;
      chk("spur_idx", BlkIdx, expIdx + 4'd1);
      chk("spur_enable", Enable, 1);
    end
  endtask

  task automatic runMb(input logic [19:0] expBot, input logic [19:0] expRight,
                       input int holdBlk, input int spurBlk);
    for (int i = 0; i < 16; i++) begin
      doBlock(tcA[i], ncA[i], 4'(i), (i > 0 && i - 1 == spurBlk) ? 0 : 1,
              (i == holdBlk) ? 5 : 0, i == spurBlk);
      if (i < 15) chk("mbdone_early", MbDone, 0);
    end
    chk("mbdone", MbDone, 1);
    chk("bot_row", BotRowTotalCoeff, expBot);
    chk("right_col", RightColTotalCoeff, expRight);
    tick();
    chk("mbdone_pulse", MbDone, 0);
    chk("mbbusy_end", MbBusy, 0);
    chk("bot_hold", BotRowTotalCoeff, expBot);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; MbStart = 1'b0; LeftMbAvail = 1'b0; TopMbAvail = 1'b0;
    LeftMbTotalCoeff = '0; TopMbTotalCoeff = '0; BarrelShifterReady = 1'b1;
    BlockDone = 1'b0; TotalCoeff = '0;
    tick();
    chk("rst_enable", Enable, 0);
    chk("rst_busy", MbBusy, 0);
    chk("rst_done", MbDone, 0);
    chk("rst_nc", nC, 0);
    chk("rst_idx", BlkIdx, 0);
    chk("rst_bot", BotRowTotalCoeff, 0);
    chk("rst_right", RightColTotalCoeff, 0);
    nReset = 1'b1;
    tick();
    // BlockDone in IDLE must do nothing.
    BlockDone = 1'b1; tick(); BlockDone = 1'b0; tick();
    chk("idle_stays", MbBusy, 0);

    // No neighbours, all TotalCoeff zero.
    for (int i = 0; i < 16; i++) begin tcA[i] = 5'd0; ncA[i] = 5'd0; end
    startMb(1'b0, 1'b0, 20'hFFFFF, 20'hFFFFF);
    chk("busy_after_start", MbBusy, 1);
    runMb(20'h0, 20'h0, -1, -1);

    // Left only, Left={3,5,7,9}, TotalCoeff = block index.
    for (int i = 0; i < 16; i++) tcA[i] = 5'(i);
    ncA = '{5'd3, 5'd0, 5'd3, 5'd2, 5'd1, 5'd4, 5'd4, 5'd6,
            5'd5, 5'd6, 5'd9, 5'd10, 5'd8, 5'd10, 5'd12, 5'd14};
    startMb(1'b1, 1'b0, 20'h49CA3, 20'hABCDE);
    runMb(20'h7B96A, 20'h7B4E5, -1, -1);

    // Both available, Left={4,2,1,0}, Top={7,16,0,3}; TC=16, block 15 TC=31.
    // Ready held low 5 cycles on block 0; spurious BlockDone/MbStart after block 3.
    for (int i = 0; i < 16; i++) tcA[i] = 5'd16;
    tcA[15] = 5'd31;
    ncA = '{5'd6, 5'd16, 5'd9, 5'd16, 5'd8, 5'd10, 5'd16, 5'd16,
            5'd9, 5'd16, 5'd8, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16};
    startMb(1'b1, 1'b1, 20'h00444, 20'h18207);
    runMb(20'hFC210, 20'hFC210, 0, 3);

    // Reset while block 7 is being prepared.
    for (int i = 0; i < 7; i++) tcA[i] = 5'd1;
    ncA[0] = 5'd4; ncA[1] = 5'd1; ncA[2] = 5'd2; ncA[3] = 5'd1;
    ncA[4] = 5'd1; ncA[5] = 5'd1; ncA[6] = 5'd1;
    startMb(1'b1, 1'b0, 20'h00444, 20'h0);
    for (int i = 0; i < 7; i++) doBlock(tcA[i], ncA[i], 4'(i), 1, 0, 1'b0);
    chk("pre_rst_idx", BlkIdx, 7);
    #1 nReset = 1'b0;
    #1;
    chk("arst_enable", Enable, 0);
    chk("arst_busy", MbBusy, 0);
    chk("arst_done", MbDone, 0);
    chk("arst_nc", nC, 0);
    chk("arst_idx", BlkIdx, 0);
    chk("arst_bot", BotRowTotalCoeff, 0);
    chk("arst_right", RightColTotalCoeff, 0);
    tick();
    nReset = 1'b1;
    tick();
    chk("post_rst_idle", MbBusy, 0);
    for (int i = 0; i < 16; i++) begin tcA[i] = 5'd0; ncA[i] = 5'd0; end
    startMb(1'b0, 1'b0, 20'h0, 20'h0);
    runMb(20'h0, 20'h0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
